// File: rtl/bcd_scan_counter.sv
// Two-digit BCD up/down counter with a count prescaler and a two-digit display scan mux.
// Optional build macro ODD_ONLY_EN: counter visits odd values only (01..99, step 2).
module bcd_scan_counter #(
  parameter int PRESCALE = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] bcd,
  output logic [3:0] digit,
  output logic [1:0] an,
  output logic       wrap
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

`ifdef ODD_ONLY_EN
  localparam logic [7:0] RST_BCD = 8'h01;
`else
  localparam logic [7:0] RST_BCD = 8'h00;
`endif

  // Scan slot state; the slot is visible on the an output.
  typedef enum logic {
    SLOT_UNITS = 1'b0,
    SLOT_TENS  = 1'b1
  } slot_e;

  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [7:0]    bcd_q, bcd_d;
  logic          wrap_q, wrap_d;
  slot_e         slot_q, slot_d;

  logic       tick;
  logic       load_ok;
  logic [7:0] load_bcd;
  logic [7:0] step_bcd;
  logic       step_roll;

  always_comb begin
    tick    = en && (pre_cnt_q == PRE_LAST);
    load_ok = load && (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);
`ifdef ODD_ONLY_EN
    load_bcd = {load_val[7:4], load_val[3:0] | 4'h1};
`else
    load_bcd = load_val;
`endif
  end

  // Per-nibble decimal step; step_roll marks the 99<->00 (or 99<->01) roll-over.
  always_comb begin
    logic [3:0] units;
    logic [3:0] tens;
    logic       carry;
    units     = bcd_q[3:0];
    tens      = bcd_q[7:4];
    carry     = 1'b0;
    step_roll = 1'b0;
    if (up) begin
`ifdef ODD_ONLY_EN
      if (units >= 4'd8) begin
        units = units - 4'd8;
        carry = 1'b1;
      end else begin
        units = units + 4'd2;
      end
`else
      if (units == 4'd9) begin
        units = 4'd0;
        carry = 1'b1;
      end else begin
        units = units + 4'd1;
      end
`endif
      if (carry) begin
        if (tens == 4'd9) begin
          tens      = 4'd0;
          step_roll = 1'b1;
        end else begin
          tens = tens + 4'd1;
        end
      end
    end else begin
`ifdef ODD_ONLY_EN
      if (units <= 4'd1) begin
        units = units + 4'd8;
        carry = 1'b1;
      end else begin
        units = units - 4'd2;
      end
`else
      if (units == 4'd0) begin
        units = 4'd9;
        carry = 1'b1;
      end else begin
        units = units - 4'd1;
      end
`endif
      if (carry) begin
        if (tens == 4'd0) begin
          tens      = 4'd9;
          step_roll = 1'b1;
        end else begin
          tens = tens - 4'd1;
        end
      end
    end
    step_bcd = {tens, units};
  end

  // Load has priority over the tick; an invalid load falls through as if absent.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    bcd_d     = bcd_q;
    wrap_d    = 1'b0;
    if (load_ok) begin
      bcd_d     = load_bcd;
      pre_cnt_d = '0;
    end else if (en) begin
      if (tick) begin
        pre_cnt_d = '0;
        bcd_d     = step_bcd;
        wrap_d    = step_roll;
      end else begin
        pre_cnt_d = pre_cnt_q + 1'b1;
      end
    end
  end

  // Scan runs regardless of en.
  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    slot_d     = slot_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      slot_d     = (slot_q == SLOT_UNITS) ? SLOT_TENS : SLOT_UNITS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q  <= '0;
      scan_cnt_q <= '0;
      bcd_q      <= RST_BCD;
      wrap_q     <= 1'b0;
      slot_q     <= SLOT_UNITS;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      bcd_q      <= bcd_d;
      wrap_q     <= wrap_d;
      slot_q     <= slot_d;
    end
  end

  always_comb begin
    bcd   = bcd_q;
    wrap  = wrap_q;
    an    = (slot_q == SLOT_UNITS) ? 2'b01 : 2'b10;
    digit = (slot_q == SLOT_UNITS) ? bcd_q[3:0] : bcd_q[7:4];
  end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter with PRESCALE=4, SCAN_DIV=3.
// Table vectors hold one cycle of inputs and the outputs expected after that cycle's edge.
module tb_bcd_scan_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] bcd;
  logic [3:0] digit;
  logic [1:0] an;
  logic       wrap;

  int checks = 0;
  int errors = 0;

`ifdef ODD_ONLY_EN
  localparam logic [7:0] RST_VAL  = 8'h01;
  localparam logic [7:0] STEP_VAL = 8'h03;
`else
  localparam logic [7:0] RST_VAL  = 8'h00;
  localparam logic [7:0] STEP_VAL = 8'h01;
`endif

  bcd_scan_counter #(.PRESCALE(4), .SCAN_DIV(3)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .bcd(bcd), .digit(digit), .an(an), .wrap(wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       rst, en, up, load;
    logic [7:0] load_val;
    logic [7:0] exp_bcd;
    logic [1:0] exp_an;
    logic [3:0] exp_digit;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic e, input logic u, input logic l,
                              input logic [7:0] lv, input logic [7:0] eb, input logic [1:0] ea,
                              input logic [3:0] ed, input logic ew);
    vec_t v;
    v.rst = r; v.en = e; v.up = u; v.load = l; v.load_val = lv;
    v.exp_bcd = eb; v.exp_an = ea; v.exp_digit = ed; v.exp_wrap = ew;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic u, input logic l, input logic [7:0] lv);
    @(negedge clk);
    rst = r; en = e; up = u; load = l; load_val = lv;
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef ODD_ONLY_EN
    add(1,0,0,0,8'h00, 8'h01,2'b01,4'h1,0);
    add(1,0,0,0,8'h00, 8'h01,2'b01,4'h1,0);
    add(0,1,1,1,8'h96, 8'h97,2'b01,4'h7,0);
    add(0,1,1,0,8'h00, 8'h97,2'b01,4'h7,0);
    add(0,1,1,0,8'h00, 8'h97,2'b10,4'h9,0);
    add(0,1,1,0,8'h00, 8'h97,2'b10,4'h9,0);
    add(0,1,1,0,8'h00, 8'h99,2'b10,4'h9,0);
    add(0,1,1,0,8'h00, 8'h99,2'b01,4'h9,0);
    add(0,1,1,0,8'h00, 8'h99,2'b01,4'h9,0);
    add(0,1,1,0,8'h00, 8'h99,2'b01,4'h9,0);
    add(0,1,1,0,8'h00, 8'h01,2'b10,4'h0,1);
    add(0,1,1,0,8'h00, 8'h01,2'b10,4'h0,0);
    add(0,1,0,1,8'h21, 8'h21,2'b10,4'h2,0);
    add(0,1,0,0,8'h00, 8'h21,2'b01,4'h1,0);
    add(0,1,0,0,8'h00, 8'h21,2'b01,4'h1,0);
    add(0,1,0,0,8'h00, 8'h21,2'b01,4'h1,0);
    add(0,1,0,0,8'h00, 8'h19,2'b10,4'h1,0);
    add(0,0,0,1,8'h48, 8'h49,2'b10,4'h4,0);
    add(0,0,0,0,8'h00, 8'h49,2'b10,4'h4,0);
    add(0,1,0,1,8'h01, 8'h01,2'b01,4'h1,0);
    add(0,1,0,0,8'h00, 8'h01,2'b01,4'h1,0);
    add(0,1,0,0,8'h00, 8'h01,2'b01,4'h1,0);
    add(0,1,0,0,8'h00, 8'h01,2'b10,4'h0,0);
    add(0,1,0,0,8'h00, 8'h99,2'b10,4'h9,1);
    add(0,1,0,0,8'h00, 8'h99,2'b10,4'h9,0);
`else
    add(1,0,0,0,8'h00, 8'h00,2'b01,4'h0,0);
    add(1,0,0,0,8'h00, 8'h00,2'b01,4'h0,0);
    add(0,1,1,0,8'h00, 8'h00,2'b01,4'h0,0);
    add(0,1,1,0,8'h00, 8'h00,2'b01,4'h0,0);
    add(0,1,1,0,8'h00, 8'h00,2'b10,4'h0,0);
    add(0,1,1,0,8'h00, 8'h01,2'b10,4'h0,0);
    add(0,1,1,0,8'h00, 8'h01,2'b10,4'h0,0);
    add(0,1,1,0,8'h00, 8'h01,2'b01,4'h1,0);
    add(0,1,1,0,8'h00, 8'h01,2'b01,4'h1,0);
    add(0,1,1,0,8'h00, 8'h02,2'b01,4'h2,0);
    add(0,1,1,0,8'h00, 8'h02,2'b10,4'h0,0);
    add(0,1,1,1,8'h98, 8'h98,2'b10,4'h9,0);
    add(0,1,1,0,8'h00, 8'h98,2'b10,4'h9,0);
    add(0,1,1,0,8'h00, 8'h98,2'b01,4'h8,0);
    add(0,1,1,0,8'h00, 8'h98,2'b01,4'h8,0);
    add(0,1,1,0,8'h00, 8'h99,2'b01,4'h9,0);
    add(0,1,1,0,8'h00, 8'h99,2'b10,4'h9,0);
    add(0,1,1,0,8'h00, 8'h99,2'b10,4'h9,0);
    add(0,1,1,0,8'h00, 8'h99,2'b10,4'h9,0);
    add(0,1,1,0,8'h00, 8'h00,2'b01,4'h0,1);
    add(0,1,1,0,8'h00, 8'h00,2'b01,4'h0,0);
    add(0,1,0,0,8'h00, 8'h00,2'b01,4'h0,0);
    add(0,1,0,0,8'h00, 8'h00,2'b10,4'h0,0);
    add(0,1,0,0,8'h00, 8'h99,2'b10,4'h9,1);
    add(0,1,0,0,8'h00, 8'h99,2'b10,4'h9,0);
    add(0,1,0,1,8'h3A, 8'h99,2'b01,4'h9,0);
    add(0,1,0,0,8'h00, 8'h99,2'b01,4'h9,0);
    add(0,1,0,0,8'h00, 8'h98,2'b01,4'h8,0);
    add(0,0,0,0,8'h00, 8'h98,2'b10,4'h9,0);
    add(0,0,0,0,8'h00, 8'h98,2'b10,4'h9,0);
    add(0,0,0,0,8'h00, 8'h98,2'b10,4'h9,0);
    add(0,0,0,0,8'h00, 8'h98,2'b01,4'h8,0);
    add(0,0,0,0,8'h00, 8'h98,2'b01,4'h8,0);
    add(0,0,0,0,8'h00, 8'h98,2'b01,4'h8,0);
    add(0,0,0,0,8'h00, 8'h98,2'b10,4'h9,0);
    add(0,1,0,1,8'h10, 8'h10,2'b10,4'h1,0);
    add(0,1,0,0,8'h00, 8'h10,2'b10,4'h1,0);
    add(0,1,0,0,8'h00, 8'h10,2'b01,4'h0,0);
    add(0,1,0,0,8'h00, 8'h10,2'b01,4'h0,0);
    add(0,1,0,0,8'h00, 8'h09,2'b01,4'h9,0);
    add(0,0,0,1,8'h47, 8'h47,2'b10,4'h4,0);
    add(0,0,0,0,8'h00, 8'h47,2'b10,4'h4,0);
    add(0,0,0,0,8'h00, 8'h47,2'b10,4'h4,0);
    add(0,0,0,0,8'h00, 8'h47,2'b01,4'h7,0);
`endif

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].load_val);
      edge_settle();
      check($sformatf("vec%0d bcd", i), bcd, vecs[i].exp_bcd);
      check($sformatf("vec%0d an", i), {6'd0, an}, {6'd0, vecs[i].exp_an});
      check($sformatf("vec%0d digit", i), {4'd0, digit}, {4'd0, vecs[i].exp_digit});
      check($sformatf("vec%0d wrap", i), {7'd0, wrap}, {7'd0, vecs[i].exp_wrap});
    end

    // Reset in the middle of a count: prescaler must restart from zero.
    drive(1, 0, 1, 0, 8'h00);
    edge_settle();
    drive(0, 1, 1, 1, 8'h47);
    edge_settle();
    drive(0, 1, 1, 0, 8'h00);
    edge_settle();
    edge_settle();
    drive(1, 1, 1, 0, 8'h00);
    edge_settle();
    check("midrst bcd", bcd, RST_VAL);
    check("midrst an", {6'd0, an}, 8'h01);
    check("midrst digit", {4'd0, digit}, {4'd0, RST_VAL[3:0]});
    check("midrst wrap", {7'd0, wrap}, 8'h00);
    drive(0, 1, 1, 0, 8'h00);
    edge_settle();
    edge_settle();
    edge_settle();
    check("midrst hold3", bcd, RST_VAL);
    edge_settle();
    check("midrst step4", bcd, STEP_VAL);

    // Roll-over from a loaded 99 must pulse wrap within a bounded number of cycles.
    drive(0, 1, 1, 1, 8'h99);
    edge_settle();
    check("load99 bcd", bcd, 8'h99);
    drive(0, 1, 1, 0, 8'h00);
    begin
      int  n;
      bit  seen;
      seen = 0;
      n    = 0;
      while (!seen && n < 12) begin
        edge_settle();
        n++;
        if (wrap === 1'b1) seen = 1;
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL wrap_wait: got no wrap in %0d cycles, expected a pulse", n);
      end else begin
        check("wrap_cycle_count", n[7:0], 8'd4);
        check("wrap bcd", bcd, RST_VAL);
        edge_settle();
        check("wrap one cycle", {7'd0, wrap}, 8'h00);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
